fdiv_seq: RTL and testbench
===========================

Name: fdiv_seq

Overview:
- Multicycle sequencer for single-precision FP division A/B on the F-extension execute path.
- Uses one MulFPU and one AddSubFPU instance, time-shared over a Newton-Raphson reciprocal sequence, then one final multiply.
- Trades latency for area versus a fully unrolled divider.
- Sits behind the FPU issue logic with a start/busy/valid handshake and a flush input for traps and branch squash.

Parameters:
- ITERS, 3, number of Newton-Raphson iterations (1..4).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in IDLE.
- flush  in  1  synchronous abort; returns to IDLE, no valid issued.
- op_a  in  32  dividend, IEEE-754 single.
- op_b  in  32  divisor, IEEE-754 single.
- busy  out  1  high whenever state != IDLE.
- out_valid  out  1  one-cycle pulse, result ready.
- result  out  32  quotient; held until the next accepted start.
- div_by_zero  out  1  sticky per operation; set with out_valid when op_b exponent == 0.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - busy = 0, out_valid = 0, result = 0, div_by_zero = 0.
  - All internal registers cleared.
- Accept: on a rising edge with state == IDLE, start = 1 and flush = 0.
  - Latch op_a and op_b.
  - Clear div_by_zero.
- Normalised divisor: D = {0, 8'd126, b[22:0]}.
- Constants: 32/17 = 0x3FF0F0F1, 48/17 = 0x4034B4B5, 2.0 = 0x40000000.
- States, one cycle each; the unit output is registered at the end of each state:
  - SEED_M: t = D*0x3FF0F0F1.
  - SEED_A: x = 0x4034B4B5 - |t|.
  - IT_M1: t = D*x.
  - IT_A: t = 2.0 - t.
  - IT_M2: x = x*t; increment iteration counter. Go to IT_M1 if counter < ITERS, else FINAL.
  - FINAL:
    - recip = {b[31], x[30:23]+8'd126-b[30:23], x[22:0]}, using 8-bit wrap-around with no overflow or underflow detection.
    - result <= a*recip.
  - DONE: out_valid = 1 for one cycle, then IDLE.
- Mux control: MulFPU operands are selected by state; AddSubFPU runs with sel = 0 and the subtrahend sign inverted. No FP unit is used combinationally across states.
- Latency:
  - out_valid is high in the cycle after the (3*ITERS+4)th rising edge following the accepting edge.
  - With ITERS = 3 that is 13 edges.
- Fast path: at accept, if a[30:23] == 0 or b[30:23] == 0:
  - Go directly to DONE (out_valid after 1 edge).
  - result = 0x00000000.
  - div_by_zero = (b[30:23] == 0).
  - b zero has priority; 0/0 also sets div_by_zero.
- Input and flush rules:
  - start while busy is ignored; the latched operands are not disturbed.
  - flush in any non-IDLE state: IDLE on the next edge, out_valid never asserted for that operation, result keeps its previous value.
  - flush and start in the same IDLE cycle: flush wins, nothing is accepted.
  - flush during DONE: out_valid in that cycle is still seen; state goes to IDLE as normal.
- Back-to-back: a new start can be accepted in the cycle after DONE (state IDLE). Throughput is 1 op per 3*ITERS+5 cycles.
- Not supported: NaN, Inf and denormals. Exponent 0 is treated as zero; exponent 255 is treated arithmetically.

Optional Feature:
- Macro: FDIV_EARLY_EXIT_EN.
- Defined:
  - At accept, if b[22:0] == 0 and b exponent != 0, the divisor is a power of two.
  - Load x = 0x40000000 and go straight to FINAL.
  - out_valid after 2 edges; result is exact.
- Undefined: every nonzero operation takes the full 3*ITERS+4 edges. The comparator and bypass path are absent.

Test Plan:
- Reset: assert rst_n low mid-operation (state IT_A) -> busy, out_valid, result and div_by_zero read 0 immediately; after release, IDLE accepts start.
- a=0x3F800000, b=0x40400000 (1/3), ITERS=3 -> out_valid after 13 edges, result 0x3EAAAAAB +/-1 ulp, div_by_zero=0, busy high for 13 cycles.
- Sign and magnitude cases:
  - a=0xC1200000, b=0x40A00000 -> result 0xC0000000 +/-1 ulp.
  - a=0x40C00000, b=0x40000000 -> 0x40400000 +/-1 ulp (exact and after 2 edges with FDIV_EARLY_EXIT_EN).
- Zero cases:
  - a=0x3F800000, b=0x00000000 -> out_valid after 1 edge, result 0, div_by_zero=1.
  - a=0, b=0x40000000 -> result 0, div_by_zero=0.
- Handshake:
  - start with new operands at edge 5 of a busy operation -> ignored, first result unchanged.
  - flush at edge 7 -> busy=0 next cycle, no out_valid, result unchanged.
  - flush+start together in IDLE -> no acceptance.
- Back-to-back: second start in the cycle after out_valid -> accepted; second out_valid exactly 14 cycles after the first; both results correct.

Source files
------------

// File: rtl/fdiv_seq.sv
// Multicycle single-precision divider: Newton-Raphson reciprocal on one shared multiplier and adder, then a*recip.
// Optional FDIV_EARLY_EXIT_EN: power-of-two divisors skip the iteration and go straight to the final multiply.
module fdiv_seq #(
  parameter int ITERS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        div_by_zero
);
  typedef enum logic [2:0] {IDLE, SEED_M, SEED_A, IT_M1, IT_A, IT_M2, FINAL, DONE} state_e;

  localparam logic [31:0] C32_17  = 32'h3FF0F0F1;
  localparam logic [31:0] C48_17  = 32'h4034B4B5;
  localparam logic [31:0] TWO     = 32'h40000000;
  localparam logic [2:0]  ITERS_W = 3'(ITERS);

  // Round-to-nearest-even multiply; exponent 0 is zero, underflow flushes to zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    logic        g, st;
    logic [30:0] mag;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 10'd1;
    end else begin
      m = p[45:23]; g = p[22]; st = |p[21:0];
    end
    mag = {e[7:0], m} + {30'd0, g & (st | m[0])};
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e[9] || e[8:0] == 9'd0)
      fp_mul = 32'd0;
    else
      fp_mul = {a[31] ^ b[31], mag};
  endfunction

  // Round-to-nearest-even add with guard/round/sticky bits.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  d;
    logic [26:0] mx, my, sh;
    logic [27:0] s;
    logic [9:0]  e;
    logic [30:0] mag;
    logic        st;
    st = 1'b0;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    if (d > 8'd26) begin
      sh = 27'd1;
    end else begin
      sh = my >> d;
      st = |(my & ((27'd1 << d) - 27'd1));
      sh[0] = sh[0] | st;
    end
    e = {2'b0, x[30:23]};
    if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, sh};
    else                s = {1'b0, mx} - {1'b0, sh};
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!s[26] && s != 28'd0) begin
          s = s << 1;
          e = e - 10'd1;
        end
      end
    end
    mag = {e[7:0], s[25:3]} + {30'd0, s[2] & (s[1] | s[0] | s[3])};
    if (x[30:23] == 8'd0)
      fp_add = 32'd0;
    else if (y[30:23] == 8'd0)
      fp_add = x;
    else if (s == 28'd0 || e[9] || e[8:0] == 9'd0)
      fp_add = 32'd0;
    else
      fp_add = {x[31], mag};
  endfunction

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, x_q, x_d, t_q, t_d, result_q, result_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        dz_q, dz_d;

  logic [31:0] d_norm, recip, mul_a, mul_b, add_a, add_b, mul_y, add_y;

  assign d_norm = {1'b0, 8'd126, b_q[22:0]};
  // Undo the divisor normalisation by moving b's exponent into the reciprocal.
  assign recip  = {b_q[31], x_q[30:23] + 8'd126 - b_q[30:23], x_q[22:0]};

  always_comb begin
    mul_a = 32'd0;
    mul_b = 32'd0;
    add_a = TWO;
    add_b = t_q;
    case (state_q)
      SEED_M:  begin mul_a = d_norm; mul_b = C32_17; end
      IT_M1:   begin mul_a = d_norm; mul_b = x_q;    end
      IT_M2:   begin mul_a = x_q;    mul_b = t_q;    end
      FINAL:   begin mul_a = a_q;    mul_b = recip;  end
      default: ;
    endcase
    if (state_q == SEED_A) begin
      add_a = C48_17;
      add_b = {1'b0, t_q[30:0]};
    end
  end

  assign mul_y = fp_mul(mul_a, mul_b);
  assign add_y = fp_add(add_a, {~add_b[31], add_b[30:0]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      x_q      <= 32'd0;
      t_q      <= 32'd0;
      result_q <= 32'd0;
      cnt_q    <= 3'd0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      x_q      <= x_d;
      t_q      <= t_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    x_d      = x_q;
    t_d      = t_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          a_d   = op_a;
          b_d   = op_b;
          cnt_d = 3'd0;
          dz_d  = 1'b0;
          if (op_a[30:23] == 8'd0 || op_b[30:23] == 8'd0) begin
            result_d = 32'd0;
            dz_d     = (op_b[30:23] == 8'd0);
            state_d  = DONE;
          end
`ifdef FDIV_EARLY_EXIT_EN
          else if (op_b[22:0] == 23'd0) begin
            x_d     = TWO;
            state_d = FINAL;
          end
`endif
          else begin
            state_d = SEED_M;
          end
        end
      end
      SEED_M: begin t_d = mul_y; state_d = SEED_A; end
      SEED_A: begin x_d = add_y; state_d = IT_M1;  end
      IT_M1:  begin t_d = mul_y; state_d = IT_A;   end
      IT_A:   begin t_d = add_y; state_d = IT_M2;  end
      IT_M2: begin
        x_d     = mul_y;
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_d < ITERS_W) ? IT_M1 : FINAL;
      end
      FINAL:   begin result_d = mul_y; state_d = DONE; end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    out_valid   = (state_q == DONE);
    result      = result_q;
    div_by_zero = dz_q;
  end
endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: directed vector table, handshake sequences and a real-arithmetic random model.
module tb_fdiv_seq;
  localparam int ITERS    = 3;
  localparam int FULL_LAT = 3 * ITERS + 4;
`ifdef FDIV_EARLY_EXIT_EN
  localparam int TOL_POW2 = 0;
`else
  localparam int TOL_POW2 = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        busy, out_valid, div_by_zero;
  logic [31:0] result;

  fdiv_seq #(.ITERS(ITERS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .busy(busy), .out_valid(out_valid),
    .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
    logic        dz;
    int          tol;
  } vec_t;

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e > 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else       for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real to_real(input logic [31:0] v);
    real r;
    if (v[30:23] == 8'd0) return 0.0;
    r = (1.0 + real'(v[22:0]) / 8388608.0) * pow2(int'(v[30:23]) - 127);
    return v[31] ? -r : r;
  endfunction

  function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 1;
`ifdef FDIV_EARLY_EXIT_EN
    if (b[22:0] == 23'd0) return 2;
`endif
    return FULL_LAT;
  endfunction

  // Within tol ulps of a known correctly-rounded quotient.
  function automatic bit near(input logic [31:0] res, input logic [31:0] want, input int tol);
    int diff;
    if (want == 32'd0) return res == 32'd0;
    if (res[31] != want[31]) return 1'b0;
    diff = int'(res[30:0]) - int'(want[30:0]);
    if (diff < 0) diff = -diff;
    return diff <= tol;
  endfunction

  // Within 2 ulps of the exact real quotient.
  function automatic bit q_ok(input logic [31:0] res, input logic [31:0] a, input logic [31:0] b);
    real q, err;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return res == 32'd0;
    q = to_real(a) / to_real(b);
    if (res[30:23] == 8'd0) return 1'b0;
    if (res[31] != (q < 0.0)) return 1'b0;
    err = to_real(res) - q;
    if (err < 0.0) err = -err;
    return err <= 2.0 * pow2(int'(res[30:23]) - 150);
  endfunction

  // inj_kind: 0 none, 1 start with inj operands, 2 flush; asserted so that edge inj_edge sees it.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int inj_edge, input int inj_kind,
                        input logic [31:0] inj_a, input logic [31:0] inj_b,
                        output logic [31:0] res, output logic dz, output int lat,
                        output int busy_cnt, output bit got_valid, output int end_edge,
                        output int unsigned vcyc);
    int guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    lat = 0; busy_cnt = 0; got_valid = 1'b0; end_edge = 0; vcyc = 0;
    res = result; dz = div_by_zero;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      end_edge = e;
      res = result; dz = div_by_zero;
      if (busy) busy_cnt++;
      if (out_valid) begin
        got_valid = 1'b1; lat = e; vcyc = cyc;
        break;
      end
      if (!busy) break;
      if (e == inj_edge - 1) begin
        if (inj_kind == 1) begin start = 1'b1; op_a = inj_a; op_b = inj_b; end
        else if (inj_kind == 2) flush = 1'b1;
      end
    end
    if (got_valid) begin
      @(posedge clk); #1;
      check("valid_pulse", !out_valid && !busy, {30'd0, busy, out_valid}, 32'd0);
    end
    $display("op %h / %h -> %h dz=%0d lat=%0d busy=%0d valid=%0d", a, b, res, dz, lat, busy_cnt, got_valid);
  endtask

  vec_t        vecs[6];
  logic [31:0] res, res2, prev;
  logic        dz;
  int          lat, bcnt, eedge, nvalid;
  bit          gv;
  int unsigned v1, v2;

  initial begin
    vecs[0] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1};
    vecs[1] = '{32'hC1200000, 32'h40A00000, 32'hC0000000, 1'b0, 1};
    vecs[2] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, TOL_POW2};
    vecs[3] = '{32'h3F800000, 32'h00000000, 32'h00000000, 1'b1, 0};
    vecs[4] = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 0};
    vecs[5] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",   busy == 1'b0,        {31'd0, busy},        32'd0);
    check("reset_valid",  out_valid == 1'b0,   {31'd0, out_valid},   32'd0);
    check("reset_result", result == 32'd0,     result,               32'd0);
    check("reset_dz",     div_by_zero == 1'b0, {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, 0, 32'd0, 32'd0, res, dz, lat, bcnt, gv, eedge, v1);
      check("vec_valid",  gv, {31'd0, gv}, 32'd1);
      check("vec_result", near(res, vecs[i].want, vecs[i].tol), res, vecs[i].want);
      check("vec_dz",     dz == vecs[i].dz, {31'd0, dz}, {31'd0, vecs[i].dz});
      check("vec_lat",    lat == lat_of(vecs[i].a, vecs[i].b), 32'(lat), 32'(lat_of(vecs[i].a, vecs[i].b)));
      check("vec_busy",   bcnt == lat_of(vecs[i].a, vecs[i].b), 32'(bcnt), 32'(lat_of(vecs[i].a, vecs[i].b)));
    end

    // Start with new operands at edge 5 of a running op must be ignored.
    run_op(32'h3F800000, 32'h40400000, 5, 1, 32'h40C00000, 32'h40000000, res, dz, lat, bcnt, gv, eedge, v1);
    check("ign_lat",    lat == FULL_LAT, 32'(lat), 32'(FULL_LAT));
    check("ign_result", near(res, 32'h3EAAAAAB, 1), res, 32'h3EAAAAAB);

    // Flush at edge 7: back to idle, no valid, result untouched.
    prev = result;
    run_op(32'hC1200000, 32'h40A00000, 7, 2, 32'd0, 32'd0, res, dz, lat, bcnt, gv, eedge, v1);
    check("flush_edge",   eedge == 7 && !busy, 32'(eedge), 32'd7);
    check("flush_novalid", !gv, {31'd0, gv}, 32'd0);
    nvalid = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (out_valid) nvalid++;
    end
    check("flush_quiet",  nvalid == 0, 32'(nvalid), 32'd0);
    check("flush_result", result == prev, result, prev);

    // Flush and start together in idle: nothing accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op_a = 32'h40C00000; op_b = 32'h40000000;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("fs_busy", !busy, {31'd0, busy}, 32'd0);
    nvalid = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (out_valid || busy) nvalid++;
    end
    check("fs_quiet",  nvalid == 0, 32'(nvalid), 32'd0);
    check("fs_result", result == prev, result, prev);

    // Back-to-back: the second start lands in the idle cycle right after the first valid.
    run_op(32'h3F800000, 32'h40400000, 0, 0, 32'd0, 32'd0, res, dz, lat, bcnt, gv, eedge, v1);
    run_op(32'hC1200000, 32'h40A00000, 0, 0, 32'd0, 32'd0, res2, dz, lat, bcnt, gv, eedge, v2);
    check("b2b_gap", v2 - v1 == 32'(FULL_LAT + 1), v2 - v1, 32'(FULL_LAT + 1));
    check("b2b_res1", near(res, 32'h3EAAAAAB, 1), res, 32'h3EAAAAAB);
    check("b2b_res2", near(res2, 32'hC0000000, 1), res2, 32'hC0000000);

    // Random operands against exact real division.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb;
      ra = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) ra[30:23] = 8'd0;
      if ($urandom_range(0, 7) == 0) rb[30:23] = 8'd0;
      if ($urandom_range(0, 7) == 0) rb[22:0]  = 23'd0;
      run_op(ra, rb, 0, 0, 32'd0, 32'd0, res, dz, lat, bcnt, gv, eedge, v1);
      check("rnd_result", gv && q_ok(res, ra, rb), res, ra);
      check("rnd_dz",     dz == (rb[30:23] == 8'd0), {31'd0, dz}, {31'd0, rb[30:23] == 8'd0});
      check("rnd_lat",    lat == lat_of(ra, rb), 32'(lat), 32'(lat_of(ra, rb)));
    end

    // Asynchronous reset in the middle of an op (state IT_A).
    @(negedge clk);
    op_a = 32'h3F800000; op_b = 32'h40400000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_busy", busy, {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",   busy == 1'b0,        {31'd0, busy},        32'd0);
    check("arst_valid",  out_valid == 1'b0,   {31'd0, out_valid},   32'd0);
    check("arst_result", result == 32'd0,     result,               32'd0);
    check("arst_dz",     div_by_zero == 1'b0, {31'd0, div_by_zero}, 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    run_op(32'h3F800000, 32'h40400000, 0, 0, 32'd0, 32'd0, res, dz, lat, bcnt, gv, eedge, v1);
    check("post_rst_lat",    lat == FULL_LAT, 32'(lat), 32'(FULL_LAT));
    check("post_rst_result", near(res, 32'h3EAAAAAB, 1), res, 32'h3EAAAAAB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
